// File: rtl/ip_test_wrapper.sv
// Single-shot NMR pulse-sequence controller: one excitation window, then one acquisition
// window, then hold in DONE until enable drops. All outputs are registered.
module ip_test_wrapper (
    input  logic         clk_0,
    input  logic         rst_0,
    input  logic [192:0] cfg_0,
    output logic [31:0]  sts_0,
    output logic [6:0]   Leds_0,
    output logic         rst_writer_0,
    output logic         rst_pck_0,
    output logic         rst_f_0,
    output logic [31:0]  size_0,
    output logic [31:0]  nb_of_sample_0,
    output logic [15:0]  cfg_amplitude_0,
    output logic [31:0]  cfg_freq_0,
    output logic         en_gen_0
);

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StExcite  = 2'd1,
        StAcquire = 2'd2,
        StDone    = 2'd3
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic [15:0] shot_q, shot_d;

    logic        rst;
    logic        enable;
    logic [31:0] exc_cycles, acq_cycles;
    logic [31:0] exc_last, acq_last;

    logic        en_gen_d, acq_d, done_d;
    logic [3:0]  onehot_d;

    logic        unused_cfg;

    assign rst        = rst_0 | ~cfg_0[0];
    assign enable     = cfg_0[1];
    assign exc_cycles = cfg_0[159:128];
    assign acq_cycles = cfg_0[191:160];
    assign unused_cfg = ^{cfg_0[15:2], cfg_0[192]};

    // A zero duration behaves like a one-cycle window.
    assign exc_last = (exc_cycles == 32'd0) ? 32'd0 : exc_cycles - 32'd1;
    assign acq_last = (acq_cycles == 32'd0) ? 32'd0 : acq_cycles - 32'd1;

    always_ff @(posedge clk_0) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= 32'd0;
            shot_q  <= 16'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shot_q  <= shot_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 32'd1;
        shot_d  = shot_q;
        unique case (state_q)
            StIdle: begin
                cnt_d = 32'd0;
                if (enable) begin
                    state_d = StExcite;
                end
            end
            StExcite: begin
                if (!enable) begin
                    state_d = StIdle;
                end else if (cnt_q == exc_last) begin
                    state_d = StAcquire;
                    cnt_d   = 32'd0;
                end
            end
            StAcquire: begin
                if (!enable) begin
                    state_d = StIdle;
                end else if (cnt_q == acq_last) begin
                    state_d = StDone;
                    shot_d  = shot_q + 16'd1;
                end
            end
            StDone: begin
                cnt_d = 32'd0;
                if (!enable) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        en_gen_d = 1'b0;
        acq_d    = 1'b0;
        done_d   = 1'b0;
        onehot_d = 4'b0001;
        unique case (state_q)
            StIdle:    onehot_d = 4'b0001;
            StExcite:  begin onehot_d = 4'b0010; en_gen_d = 1'b1; end
            StAcquire: begin onehot_d = 4'b0100; acq_d    = 1'b1; end
            StDone:    begin onehot_d = 4'b1000; done_d   = 1'b1; end
            default:   onehot_d = 4'b0001;
        endcase
    end

    always_ff @(posedge clk_0) begin
        if (rst) begin
            sts_0        <= 32'd0;
            Leds_0       <= 7'b0000001;
            rst_writer_0 <= 1'b1;
            rst_pck_0    <= 1'b1;
            rst_f_0      <= 1'b1;
            en_gen_0     <= 1'b0;
        end else begin
            sts_0        <= {shot_q, 11'd0, done_d, acq_d, en_gen_d, state_q};
            Leds_0       <= {done_d, en_gen_d, enable, onehot_d};
            rst_writer_0 <= ~acq_d;
            rst_pck_0    <= ~acq_d;
            rst_f_0      <= ~acq_d;
            en_gen_0     <= en_gen_d;
        end
    end

    // Parameters track the config word only while idle; frozen for the whole shot.
    always_ff @(posedge clk_0) begin
        if (rst) begin
            size_0          <= 32'd0;
            nb_of_sample_0  <= 32'd0;
            cfg_amplitude_0 <= 16'd0;
            cfg_freq_0      <= 32'd0;
        end else if (state_q == StIdle) begin
            size_0          <= cfg_0[63:32];
            nb_of_sample_0  <= cfg_0[95:64];
            cfg_amplitude_0 <= cfg_0[31:16];
            cfg_freq_0      <= cfg_0[127:96];
        end
    end

endmodule

// File: tb/tb_ip_test_wrapper.sv
// Randomized scoreboard bench for ip_test_wrapper; expected outputs come from a
// shot-timeline model (elapsed cycles since enable vs. window lengths).
module tb_ip_test_wrapper;

    logic         clk_0;
    logic         rst_0;
    logic [192:0] cfg_0;
    logic [31:0]  sts_0;
    logic [6:0]   Leds_0;
    logic         rst_writer_0, rst_pck_0, rst_f_0;
    logic [31:0]  size_0, nb_of_sample_0, cfg_freq_0;
    logic [15:0]  cfg_amplitude_0;
    logic         en_gen_0;

    ip_test_wrapper dut (
        .clk_0          (clk_0),
        .rst_0          (rst_0),
        .cfg_0          (cfg_0),
        .sts_0          (sts_0),
        .Leds_0         (Leds_0),
        .rst_writer_0   (rst_writer_0),
        .rst_pck_0      (rst_pck_0),
        .rst_f_0        (rst_f_0),
        .size_0         (size_0),
        .nb_of_sample_0 (nb_of_sample_0),
        .cfg_amplitude_0(cfg_amplitude_0),
        .cfg_freq_0     (cfg_freq_0),
        .en_gen_0       (en_gen_0)
    );

    initial clk_0 = 1'b0;
    always #5 clk_0 = ~clk_0;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // {sts, leds, rst_writer, rst_pck, rst_f, en_gen}
    logic [42:0]  exp_ctrl_q[$];
    // {amplitude, size, nb_of_sample, freq}
    logic [111:0] exp_par_q[$];

    // Shot timeline: active means a shot is under way; k counts cycles since enable was taken.
    bit          m_active = 1'b0;
    longint      m_k      = 0;
    logic [15:0] m_shot   = 16'd0;
    logic [111:0] m_par   = '0;

    function automatic int phase_of(input longint e, input longint a);
        if (!m_active)     return 0;
        if (m_k <= e)      return 1;
        if (m_k <= e + a)  return 2;
        return 3;
    endfunction

    // Predict the outputs visible after the next clock edge, given the inputs held until then.
    function automatic void model_step(input logic r, input logic [192:0] c);
        longint      e, a;
        int          ph;
        logic [15:0] shot_out;
        logic [3:0]  onehot;
        logic [2:0]  rsts;
        if (r || !c[0]) begin
            m_active = 1'b0;
            m_k      = 0;
            m_shot   = 16'd0;
            m_par    = '0;
            exp_ctrl_q.push_back({32'd0, 7'b0000001, 3'b111, 1'b0});
            exp_par_q.push_back(112'd0);
            return;
        end
        e = longint'(c[159:128]);
        a = longint'(c[191:160]);
        if (e == 0) e = 1;
        if (a == 0) a = 1;
        // Outputs lag the sequencer by one cycle, so they reflect the phase before this edge.
        ph       = phase_of(e, a);
        shot_out = m_shot;
        if (!m_active) begin
            m_par = {c[31:16], c[63:32], c[95:64], c[127:96]};
            if (c[1]) begin
                m_active = 1'b1;
                m_k      = 1;
            end
        end else if (m_k <= e + a) begin
            if (!c[1]) begin
                m_active = 1'b0;
            end else begin
                m_k++;
                if (m_k == e + a + 1) m_shot = m_shot + 16'd1;
            end
        end else if (!c[1]) begin
            m_active = 1'b0;
        end
        onehot = 4'b0001 << ph;
        rsts   = (ph == 2) ? 3'b000 : 3'b111;
        exp_ctrl_q.push_back({shot_out, 11'd0, 1'(ph == 3), 1'(ph == 2), 1'(ph == 1), 2'(ph),
                              1'(ph == 3), 1'(ph == 1), c[1], onehot, rsts, 1'(ph == 1)});
        exp_par_q.push_back(m_par);
    endfunction

    function automatic logic [192:0] mk(input bit run, input bit en, input logic [15:0] amp,
                                        input logic [31:0] sz, input logic [31:0] nb,
                                        input logic [31:0] fr, input logic [31:0] ex,
                                        input logic [31:0] aq);
        logic [192:0] c;
        c            = '0;
        c[0]         = run;
        c[1]         = en;
        c[31:16]     = amp;
        c[63:32]     = sz;
        c[95:64]     = nb;
        c[127:96]    = fr;
        c[159:128]   = ex;
        c[191:160]   = aq;
        return c;
    endfunction

    task automatic step(input logic r, input logic [192:0] c);
        @(posedge clk_0);
        #2;
        rst_0 = r;
        cfg_0 = c;
        model_step(r, c);
    endtask

    task automatic steps(input int n, input logic r, input logic [192:0] c);
        for (int i = 0; i < n; i++) step(r, c);
    endtask

    // Monitor: every clock the DUT presents a full output vector; compare against the queue head.
    initial begin
        logic [42:0]  ec, gc;
        logic [111:0] ep, gp;
        forever begin
            @(posedge clk_0);
            #1;
            cyc++;
            if (exp_ctrl_q.size() > 0) begin
                ec = exp_ctrl_q.pop_front();
                ep = exp_par_q.pop_front();
                gc = {sts_0, Leds_0, rst_writer_0, rst_pck_0, rst_f_0, en_gen_0};
                gp = {cfg_amplitude_0, size_0, nb_of_sample_0, cfg_freq_0};
                checks++;
                if (gc !== ec) begin
                    errors++;
                    $display("FAIL ctrl cyc=%0d got sts=%h leds=%b rst=%b en_gen=%b want sts=%h leds=%b rst=%b en_gen=%b",
                             cyc, gc[42:11], gc[10:4], gc[3:1], gc[0],
                             ec[42:11], ec[10:4], ec[3:1], ec[0]);
                end
                checks++;
                if (gp !== ep) begin
                    errors++;
                    $display("FAIL params cyc=%0d got=%h want=%h", cyc, gp, ep);
                end
            end
        end
    end

    initial begin
        logic [192:0] base, c;
        logic [15:0]  amp;
        logic [31:0]  sz, nb, fr, ex, aq;
        int           hold;
        rst_0 = 1'b1;
        cfg_0 = '0;

        // Hard reset
        steps(3, 1'b1, '0);

        // Parameter pass-through while idle
        base = mk(1, 0, 16'd1024, 32'd1025, 32'd1026, 32'd1027, 32'd12, 32'd12);
        steps(2, 1'b0, base);

        // Nominal shot, then hold in DONE
        steps(30, 1'b0, base | 193'd2);

        // Soft reset and re-arm
        steps(2, 1'b0, '0);
        steps(1, 1'b0, base);
        steps(30, 1'b0, base | 193'd2);

        // Abort at the fifth excitation cycle
        steps(2, 1'b0, base);
        steps(5, 1'b0, base | 193'd2);
        steps(3, 1'b0, base);

        // Zero durations
        base = mk(1, 0, 16'hBEEF, 32'd7, 32'd8, 32'd9, 32'd0, 32'd0);
        steps(2, 1'b0, base);
        steps(6, 1'b0, base | 193'd2);
        steps(2, 1'b0, base);

        // Random shots with random holds, aborts, reserved bits and occasional resets
        for (int it = 0; it < 40; it++) begin
            steps(1, 1'b0, base);
            amp  = 16'($urandom);
            sz   = $urandom;
            nb   = $urandom;
            fr   = $urandom;
            ex   = $urandom_range(0, 10);
            aq   = $urandom_range(0, 10);
            base = mk(1, 0, amp, sz, nb, fr, ex, aq);
            c    = base;
            c[15:2] = 14'($urandom);
            c[192]  = 1'($urandom);
            steps(int'($urandom_range(1, 2)), 1'b0, c);
            hold = int'($urandom_range(1, 28));
            for (int h = 0; h < hold; h++) begin
                c    = base | 193'd2;
                c[192] = 1'($urandom);
                case ($urandom_range(0, 29))
                    0:       step(1'b1, c);
                    1:       step(1'b0, c & ~193'd1);
                    default: step(1'b0, c);
                endcase
            end
            steps(int'($urandom_range(1, 3)), 1'b0, base);
        end

        @(posedge clk_0);
        @(posedge clk_0);
        #2;
        checks++;
        if (exp_ctrl_q.size() != 0) begin
            errors++;
            $display("FAIL drain got=%0d pending want=0", exp_ctrl_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ip_test_wrapper.md
# ip_test_wrapper

Single-shot NMR pulse-sequence controller driven by a packed configuration word from the PS (AXI config register). When enabled, it runs one excitation window, gating the signal generator, followed by one acquisition window, releasing the writer, packetizer and FIFO resets. It then reports completion through a status word and LEDs. It also forwards generator and acquisition parameters to the neighbouring cores.

## Interface
Parameters: none (all field positions and widths are fixed).

- clk_0  in  1  system clock; everything is on its rising edge
- rst_0  in  1  synchronous, active-high reset
- cfg_0  in  193  config word:
  - [0] run_n: 0 = soft reset, identical in effect to rst_0
  - [1] enable
  - [15:2] reserved
  - [31:16] amplitude
  - [63:32] size
  - [95:64] nb_of_sample
  - [127:96] freq
  - [159:128] excitation cycles
  - [191:160] acquisition cycles
  - [192] reserved
- sts_0  out  32  status:
  - [1:0] state
  - [2] en_gen
  - [3] acquiring
  - [4] done
  - [15:5] 0
  - [31:16] shot counter
- Leds_0  out  7  LEDs:
  - [3:0] one-hot state (IDLE, EXCITE, ACQUIRE, DONE)
  - [4] enable
  - [5] en_gen
  - [6] done
- rst_writer_0  out  1  active-high reset to the DMA writer
- rst_pck_0  out  1  active-high reset to the packetizer
- rst_f_0  out  1  active-high reset to the FIFO
- size_0  out  32  latched size
- nb_of_sample_0  out  32  latched nb_of_sample
- cfg_amplitude_0  out  16  latched amplitude
- cfg_freq_0  out  32  latched freq
- en_gen_0  out  1  generator enable

## Operation
- Internal reset rst = rst_0 OR NOT cfg_0[0], applied synchronously.
- FSM encoding: IDLE = 0, EXCITE = 1, ACQUIRE = 2, DONE = 3.
- IDLE:
  - Resets to downstream are asserted (1); en_gen = 0.
  - The four parameter outputs reload from cfg_0 every cycle.
  - On enable = 1, go to EXCITE and clear the cycle counter.
- EXCITE:
  - en_gen = 1.
  - Stay for max(exc, 1) cycles, then go to ACQUIRE and clear the counter.
- ACQUIRE:
  - rst_writer, rst_pck and rst_f = 0; acquiring = 1.
  - Stay for max(acq, 1) cycles, then go to DONE.
  - The shot counter increments (16-bit, wraps) on this transition.
- DONE:
  - Downstream resets reasserted; done = 1.
  - Hold until enable = 0, then return to IDLE. This gives exactly one shot per enable assertion.
- Parameter outputs are frozen in every state other than IDLE.
- Abort: if enable = 0 while in EXCITE or ACQUIRE, go to IDLE on the next cycle. en_gen drops and resets reassert; the shot counter is not incremented.
- Counter is 32-bit. The comparison is counter == duration − 1, with a duration of 0 treated as 1.

## Timing
- All outputs are registered. Reset values:
  - state IDLE, sts_0 = 0, Leds_0 = 7'b0000001
  - rst_writer_0 = rst_pck_0 = rst_f_0 = 1
  - en_gen_0 = 0
  - size_0, nb_of_sample_0, cfg_amplitude_0, cfg_freq_0 = 0
  - shot counter = 0
- Latency: enable sampled high at edge N gives en_gen_0 = 1 from edge N+1.
- en_gen_0 is high for exactly max(exc, 1) consecutive cycles.
- The downstream resets deassert on the edge where en_gen_0 falls. They stay low for exactly max(acq, 1) cycles; there is no gap and no overlap with en_gen.
- done (sts_0[4]) rises on the edge where the resets reassert.
- Parameter outputs follow cfg_0 with 1 cycle of latency while in IDLE.
- Reset, hard or soft, has priority over all transitions, including in the middle of a shot.

## Test plan
- Reset: rst_0 = 1 for 3 cycles → resets = 1, en_gen = 0, Leds = 0000001, sts = 0, all parameter outputs 0.
- Parameter pass-through: cfg_0[0] = 1, amplitude = 1024, size = 1025, nb_of_sample = 1026, freq = 1027, enable = 0 → one cycle later the outputs equal 1024 / 1025 / 1026 / 1027.
- Nominal shot: exc = acq = 12, cfg[0] = 1, then cfg[1] = 1 → en_gen high for 12 cycles starting 1 cycle later; then resets low for 12 cycles; then DONE with sts[4] = 1, sts[31:16] = 1 and Leds = 1001000 | enable bit. The machine stays in DONE while enable is held.
- Re-arm: clear cfg to 0 (soft reset), reload the same fields, set cfg[0] then cfg[1] → the full sequence repeats; the shot counter reads 1 because the soft reset cleared it.
- Abort: drop enable at cycle 5 of EXCITE → IDLE next cycle, en_gen = 0, resets stay 1, shot counter unchanged.
- Zero durations: exc = acq = 0 → en_gen high 1 cycle, resets low 1 cycle, DONE reached 3 cycles after enable is sampled.
